param_ram: RTL and testbench
============================

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width; depth = 2**ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra busy cycles per access (0..15 legal).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mov  input  1  access request, level, held until moc seen.
REQ-006 SHALL have port rw  input  1  1 = read, 0 = write.
REQ-007 SHALL have port addr  input  ADDR_W  byte address of most-significant byte.
REQ-008 SHALL have port data_in  input  64  write data, right-justified.
REQ-009 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-010 SHALL have port is_signed  input  1  sign-extend read data.
REQ-011 SHALL have port data_out  output  64  read data, right-justified.
REQ-012 SHALL have port moc  output  1  access complete.
REQ-013 SHALL have port err  output  1  access rejected (see Configuration).

Function
REQ-014 SHALL store data big-endian: byte at addr is most significant of the accessed item.
REQ-015 SHALL use FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-016 In IDLE with mov=1 at a rising edge, SHALL latch rw, addr, size, is_signed, data_in and enter BUSY.
REQ-017 SHALL stay in BUSY exactly WAIT_CYCLES cycles (WAIT_CYCLES=0: one edge straight to DONE), then enter DONE.
REQ-018 On BUSY->DONE edge SHALL perform the write or update data_out, and set moc=1 (registered).
REQ-019 In DONE SHALL hold moc=1 while mov=1; on first edge with mov=0 SHALL clear moc and enter IDLE.
REQ-020 A new request SHALL not start in the same edge that leaves DONE; minimum one IDLE cycle between accesses.
REQ-021 Changes on rw/addr/size/data_in/is_signed after launch SHALL not affect the access in flight.
REQ-022 mov falling during BUSY SHALL not abort; access completes, moc pulses high one cycle, then IDLE.
REQ-023 Reads: byte/half/word SHALL zero-extend, or sign-extend from item MSB when is_signed=1; doubleword ignores is_signed.
REQ-024 data_out SHALL hold its value until the next completed read; writes SHALL not change it.
REQ-025 Multi-byte addresses SHALL wrap modulo 2**ADDR_W (addr 0xFF word touches 0xFF,0x00,0x01,0x02 at ADDR_W=8).
REQ-026 err SHALL be registered, valid with moc, and clear when leaving DONE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, moc=0, err=0, data_out=0.
REQ-028 Reset during BUSY SHALL discard the access; no memory byte written.
REQ-029 Memory array contents SHALL not be reset.

Configuration
REQ-030 Macro PARAM_RAM_ALIGN_CHECK_EN SHALL select alignment checking.
REQ-031 With macro defined: addr not a multiple of item size SHALL complete normally in timing with moc=1, err=1, no memory write, data_out unchanged.
REQ-032 Without macro: err SHALL be constant 0 and misaligned accesses SHALL proceed with wrap per REQ-025.

Verification
REQ-033 Write word 0xDEADBEEF at 0x10, read bytes 0x10..0x13 unsigned -> data_out 0xDE,0xAD,0xBE,0xEF zero-extended.
REQ-034 Write byte 0x80 at 0x20, read byte is_signed=1 -> 0xFFFFFFFFFFFFFF80; is_signed=0 -> 0x0000000000000080.
REQ-035 Write doubleword 0x0123456789ABCDEF at 0x40, read doubleword -> same value; moc rises WAIT_CYCLES+1 edges after mov sampled, falls one edge after mov=0.
REQ-036 Without macro, write word 0xCAFEF00D at 0xFE -> byte 0x00 reads 0xF0, byte 0x01 reads 0x0D; with macro same access -> err=1, bytes unchanged.
REQ-037 Launch write 0x55 at 0x30 over prior 0xAA, assert rst_n=0 during BUSY -> moc/data_out 0 at once, later read of 0x30 returns 0xAA.
REQ-038 Drop mov during BUSY -> access completes, moc high exactly one cycle, FSM back in IDLE.

Source files
------------

// File: rtl/param_ram.sv
// Byte-addressed big-endian RAM with a mov/moc handshake and configurable busy time.
// Define PARAM_RAM_ALIGN_CHECK_EN to reject misaligned accesses with err.
module param_ram #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mov,
  input  logic          rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]   data_in,
  input  logic [1:0]    size,
  input  logic          is_signed,
  output logic [63:0]   data_out,
  output logic          moc,
  output logic          err
);
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;

  logic              rw_q, sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [63:0]       data_q;
  logic [3:0]        cnt;
  logic              finish, reject, mem_we;

  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;
  logic [NUM_LANES-1:0]             lane_mask;
  logic [63:0]                      wr_left, rd_left, rd_ext;

  logic [7:0] mem [DEPTH];

  assign finish = (state == BUSY) && (cnt == 4'(WAIT_CYCLES));
  assign mem_we = finish && !rw_q && !reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mov)    next_state = BUSY;
      BUSY:    if (finish) next_state = DONE;
      DONE:    if (!mov)   next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Lane i carries the byte at addr+i; lane 0 is the item's most significant byte.
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_addr[i] = addr_q + ADDR_W'(i);
      assign rd_left[63-8*i -: 8] = mem[lane_addr[i]];
    end
  endgenerate

  always_comb begin
    lane_mask = 8'hFF;
    wr_left   = data_q;
    rd_ext    = rd_left;
    case (size_q)
      2'b00: begin
        lane_mask = 8'h01;
        wr_left   = {data_q[7:0], 56'b0};
        rd_ext    = {{56{sgn_q & rd_left[63]}}, rd_left[63:56]};
      end
      2'b01: begin
        lane_mask = 8'h03;
        wr_left   = {data_q[15:0], 48'b0};
        rd_ext    = {{48{sgn_q & rd_left[63]}}, rd_left[63:48]};
      end
      2'b10: begin
        lane_mask = 8'h0F;
        wr_left   = {data_q[31:0], 32'b0};
        rd_ext    = {{32{sgn_q & rd_left[63]}}, rd_left[63:32]};
      end
      default: ;
    endcase
  end

`ifdef PARAM_RAM_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    case (size_q)
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      2'b11:   misaligned = |addr_q[2:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign reject = misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err <= 1'b0;
    else if (finish)                    err <= misaligned;
    else if (state == DONE && !mov)     err <= 1'b0;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q     <= 1'b0;
      sgn_q    <= 1'b0;
      addr_q   <= '0;
      size_q   <= 2'b00;
      data_q   <= 64'b0;
      cnt      <= 4'd0;
      moc      <= 1'b0;
      data_out <= 64'b0;
    end else begin
      if (state == IDLE && mov) begin
        rw_q   <= rw;
        sgn_q  <= is_signed;
        addr_q <= addr;
        size_q <= size;
        data_q <= data_in;
        cnt    <= 4'd0;
      end else if (state == BUSY && !finish) begin
        cnt <= cnt + 4'd1;
      end
      if (finish) begin
        moc <= 1'b1;
        if (rw_q && !reject) data_out <= rd_ext;
      end else if (state == DONE && !mov) begin
        moc <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (mem_we && lane_mask[l]) mem[lane_addr[l]] <= wr_left[63-8*l -: 8];
  end
endmodule

// File: tb/tb_param_ram.sv
// Directed self-checking bench for param_ram (ADDR_W=8, WAIT_CYCLES=1).
module tb_param_ram;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n, mov, rw, is_signed;
  logic [7:0]  addr;
  logic [63:0] data_in, data_out;
  logic [1:0]  size;
  logic        moc, err;

  int checks = 0;
  int errors = 0;
  int lat;
  logic moc_after, err_seen;

  param_ram #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .mov(mov), .rw(rw), .addr(addr), .data_in(data_in),
    .size(size), .is_signed(is_signed), .data_out(data_out), .moc(moc), .err(err)
  );

  always #5 clk = ~clk;

  // Runs one full handshake; inputs are scrambled right after launch.
  task automatic access(input logic r, input logic [7:0] a, input logic [1:0] sz,
                        input logic sg, input logic [63:0] d,
                        output int l, output logic mf, output logic es);
    @(negedge clk);
    rw = r; addr = a; size = sz; is_signed = sg; data_in = d; mov = 1'b1;
    @(posedge clk); #1;
    rw = ~r; addr = ~a; size = ~sz; is_signed = ~sg; data_in = ~d;
    l = 0;
    while (!moc && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    es = err;
    if (!moc) begin
      checks++; errors++;
      $display("FAIL access_timeout addr %h got moc %b exp 1", a, moc);
    end
    @(negedge clk); mov = 1'b0;
    @(posedge clk); #1;
    mf = moc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mov = 1'b0; rw = 1'b0; addr = 8'h00; size = 2'b00;
    is_signed = 1'b0; data_in = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (moc !== 1'b0) begin errors++; $display("FAIL reset_moc got %b exp 0", moc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_bytes;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    access(1'b0, 8'h10, 2'b10, 1'b0, 64'h1111_2222_DEAD_BEEF, lat, moc_after, err_seen);
    for (int k = 0; k < 4; k++) begin
      access(1'b1, 8'h10 + 8'(k), 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
      checks++;
      if (data_out !== {56'h0, exp_b[k]}) begin
        errors++; $display("FAIL word_byte%0d got %h exp %h", k, data_out, {56'h0, exp_b[k]});
      end
    end
    access(1'b1, 8'h10, 2'b10, 1'b1, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'hFFFF_FFFF_DEAD_BEEF) begin
      errors++; $display("FAIL word_signed got %h exp ffffffffdeadbeef", data_out);
    end
    access(1'b1, 8'h12, 2'b01, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'h0000_0000_0000_BEEF) begin
      errors++; $display("FAIL half_unsigned got %h exp beef", data_out);
    end
  endtask

  task automatic test_sign;
    access(1'b0, 8'h20, 2'b00, 1'b0, 64'h80, lat, moc_after, err_seen);
    access(1'b1, 8'h20, 2'b00, 1'b1, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++; $display("FAIL byte_signed got %h exp ffffffffffffff80", data_out);
    end
    access(1'b1, 8'h20, 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'h80) begin
      errors++; $display("FAIL byte_unsigned got %h exp 80", data_out);
    end
  endtask

  task automatic test_dword_timing;
    access(1'b0, 8'h40, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'h80) begin
      errors++; $display("FAIL write_keeps_data got %h exp 80", data_out);
    end
    checks++;
    if (lat != W + 1) begin errors++; $display("FAIL write_latency got %0d exp %0d", lat, W + 1); end
    access(1'b1, 8'h40, 2'b11, 1'b1, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL dword_read got %h exp 0123456789abcdef", data_out);
    end
    checks++;
    if (lat != W + 1) begin errors++; $display("FAIL read_latency got %0d exp %0d", lat, W + 1); end
    checks++;
    if (moc_after !== 1'b0) begin errors++; $display("FAIL moc_fall got %b exp 0", moc_after); end
    checks++;
    if (err_seen !== 1'b0) begin errors++; $display("FAIL aligned_err got %b exp 0", err_seen); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_b [4];
`ifdef PARAM_RAM_ALIGN_CHECK_EN
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int k = 0; k < 4; k++)
      access(1'b0, 8'hFE + 8'(k), 2'b00, 1'b0, {56'h0, exp_b[k]}, lat, moc_after, err_seen);
    access(1'b1, 8'h01, 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
    access(1'b0, 8'hFE, 2'b10, 1'b0, 64'hCAFE_F00D, lat, moc_after, err_seen);
    checks++;
    if (err_seen !== 1'b1) begin errors++; $display("FAIL misaligned_err got %b exp 1", err_seen); end
    checks++;
    if (lat != W + 1) begin errors++; $display("FAIL misaligned_latency got %0d exp %0d", lat, W + 1); end
    checks++;
    if (data_out !== 64'h44) begin errors++; $display("FAIL misaligned_data got %h exp 44", data_out); end
    access(1'b1, 8'h41, 2'b01, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'h44 || err_seen !== 1'b1) begin
      errors++; $display("FAIL misaligned_read got %h err %b exp 44 err 1", data_out, err_seen);
    end
`else
    exp_b[0] = 8'hCA; exp_b[1] = 8'hFE; exp_b[2] = 8'hF0; exp_b[3] = 8'h0D;
    access(1'b0, 8'hFE, 2'b10, 1'b0, 64'hCAFE_F00D, lat, moc_after, err_seen);
    checks++;
    if (err_seen !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", err_seen); end
`endif
    for (int k = 0; k < 4; k++) begin
      access(1'b1, 8'hFE + 8'(k), 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
      checks++;
      if (data_out !== {56'h0, exp_b[k]}) begin
        errors++; $display("FAIL wrap_byte%0d got %h exp %h", k, data_out, {56'h0, exp_b[k]});
      end
    end
  endtask

  task automatic test_reset_busy;
    access(1'b0, 8'h30, 2'b00, 1'b0, 64'hAA, lat, moc_after, err_seen);
    access(1'b1, 8'h30, 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'hAA) begin errors++; $display("FAIL pre_reset_read got %h exp aa", data_out); end
    @(negedge clk);
    rw = 1'b0; addr = 8'h30; size = 2'b00; data_in = 64'h55; mov = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (moc !== 1'b0 || data_out !== 64'h0) begin
      errors++; $display("FAIL busy_reset got moc %b data %h exp 0 0", moc, data_out);
    end
    @(negedge clk); mov = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    access(1'b1, 8'h30, 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (data_out !== 64'hAA) begin errors++; $display("FAIL discarded_write got %h exp aa", data_out); end
  endtask

  task automatic test_mov_drop;
    int hi, rise_at;
    @(negedge clk);
    rw = 1'b1; addr = 8'h40; size = 2'b11; is_signed = 1'b0; mov = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); mov = 1'b0;
    hi = 0; rise_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (moc) begin
        hi++;
        if (rise_at < 0) rise_at = c;
      end
    end
    checks++;
    if (hi != 1) begin errors++; $display("FAIL drop_moc_cycles got %0d exp 1", hi); end
    checks++;
    if (rise_at != W + 1) begin errors++; $display("FAIL drop_moc_edge got %0d exp %0d", rise_at, W + 1); end
    checks++;
    if (data_out !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL drop_data got %h exp 0123456789abcdef", data_out);
    end
    access(1'b1, 8'h47, 2'b00, 1'b0, 64'h0, lat, moc_after, err_seen);
    checks++;
    if (lat != W + 1 || data_out !== 64'hEF) begin
      errors++; $display("FAIL after_drop got lat %0d data %h exp %0d ef", lat, data_out, W + 1);
    end
  endtask

  initial begin
    test_reset;
    test_word_bytes;
    test_sign;
    test_dword_timing;
    test_wrap;
    test_reset_busy;
    test_mov_drop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
